// File: rtl/asip_pkg.sv
// Shared ISA constants and loader state encoding for the ASIP instruction path.
package asip_pkg;

    localparam int INSTR_W  = 17;
    localparam int TYPE_MSB = 16;
    localparam int TYPE_LSB = 15;

    localparam logic [1:0] TYPE_DATA   = 2'b00;
    localparam logic [1:0] TYPE_MEM    = 2'b01;
    localparam logic [1:0] TYPE_BRANCH = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        B0,
        B1,
        B2,
        WRITE,
        CHK,
        DONE,
        ERROR
    } loader_state_t;

    function automatic logic type_legal(input logic [1:0] t);
        return (t == TYPE_DATA) || (t == TYPE_MEM) || (t == TYPE_BRANCH);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects the first two payload bytes of a word; the third byte is combined live
// so the loader can range-check the full word in the same cycle it arrives.
module word_assembler
    import asip_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en,
    input  logic [7:0]         byte_data,
    output logic [INSTR_W-1:0] word,
    output logic               pad_err
);

    logic [15:0] sr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_reg <= '0;
        end else if (shift_en) begin
            sr_reg <= {byte_data, sr_reg[15:8]};
        end
    end

    // After b0 and b1 the register holds {b1, b0}; only bit 0 of b2 is meaningful.
    assign word    = {byte_data[0], sr_reg};
    assign pad_err = |byte_data[7:1];

endmodule

// File: rtl/program_loader.sv
// Length-prefixed byte-stream loader for the ASIP IMEM; holds the core in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader
    import asip_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W:0]    instr_count
);

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    loader_state_t      state_reg, state_next;
    logic [7:0]         len_lo_reg;
    logic [15:0]        len_reg;
    logic [ADDR_W:0]    count_reg;
    logic               we_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [INSTR_W-1:0] wdata_reg;
    logic [INSTR_W-1:0] word;
    logic               pad_err;
    logic               xfer;
    logic               can_start;
    logic               last_word;
    logic [15:0]        len_full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_reg;
`endif

    assign xfer      = byte_valid && byte_ready;
    assign can_start = start && (state_reg == IDLE || state_reg == DONE || state_reg == ERROR);
    assign last_word = (16'(count_reg) + 16'd1) == len_reg;
    assign len_full  = {byte_data, len_lo_reg};

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (xfer && (state_reg == B0 || state_reg == B1)),
        .byte_data (byte_data),
        .word      (word),
        .pad_err   (pad_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_hold   = 1'b1;
        case (state_reg)
            IDLE: begin
                if (start) state_next = LEN_LO;
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer) state_next = LEN_HI;
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer) begin
                    state_next = (len_full == 16'd0 || len_full > DEPTH16) ? ERROR : B0;
                end
            end
            B0: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer) state_next = B1;
            end
            B1: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer) state_next = B2;
            end
            B2: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer) begin
                    if (pad_err || !type_legal(word[TYPE_MSB:TYPE_LSB])) begin
                        state_next = ERROR;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                state_next = last_word ? CHK : B0;
`else
                state_next = last_word ? DONE : B0;
`endif
            end
            CHK: begin
                busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                byte_ready = 1'b1;
                if (xfer) state_next = (byte_data == csum_reg) ? DONE : ERROR;
`else
                state_next = ERROR;
`endif
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_next = LEN_LO;
            end
            ERROR: begin
                err = 1'b1;
                if (start) state_next = LEN_LO;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_lo_reg <= '0;
            len_reg    <= '0;
            count_reg  <= '0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else begin
            if (can_start) count_reg <= '0;
            if (xfer && state_reg == LEN_LO) len_lo_reg <= byte_data;
            if (xfer && state_reg == LEN_HI) len_reg <= len_full;
            if (state_reg == WRITE) count_reg <= count_reg + 1'b1;
            // The strobe is registered so it is high exactly during the WRITE cycle.
            we_reg <= (state_reg == B2) && (state_next == WRITE);
            if ((state_reg == B2) && (state_next == WRITE)) begin
                addr_reg  <= count_reg[ADDR_W-1:0];
                wdata_reg <= word;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_reg <= '0;
        end else if (can_start) begin
            csum_reg <= '0;
        end else if (xfer && (state_reg == B0 || state_reg == B1 || state_reg == B2)) begin
            csum_reg <= csum_reg ^ byte_data;
        end
    end
`endif

    assign imem_we     = we_reg;
    assign imem_addr   = addr_reg;
    assign imem_wdata  = wdata_reg;
    assign instr_count = count_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal, length/field errors, backpressure, reset mid-load.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [16:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  instr_count;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0]  wr_addr [64];
    logic [16:0] wr_data [64];
    int          wr_n = 0;
    int          ready_in_write = 0;
    logic [7:0]  stream [$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .instr_count (instr_count)
    );

    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = imem_addr;
                wr_data[wr_n] = imem_wdata;
            end
            wr_n++;
            if (byte_ready) ready_in_write++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("byte_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic pulse_start;
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input string tag, input bit gaps);
        int n = 0;
        pulse_start();
        foreach (stream[i]) send_byte(stream[i], gaps ? int'($urandom_range(0, 3)) : 0);
        while (!(done || err) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({tag, "_end_timeout"}, 32'(n), 32'd0);
        byte_valid = 1'b0;
        @(negedge clk);
        $display("load %s: writes=%0d count=%0d done=%0d err=%0d hold=%0d",
                 tag, wr_n, instr_count, done, err, cpu_hold);
    endtask

    task automatic nominal_stream;
        stream = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'h00, 8'h80, 8'h00};
    endtask

    task automatic check_nominal(input string tag, input int base);
        check({tag, "_nwr"},   32'(wr_n - base), 32'd2);
        check({tag, "_a0"},    32'(wr_addr[base]), 32'h00);
        check({tag, "_d0"},    32'(wr_data[base]), 32'h11234);
        check({tag, "_a1"},    32'(wr_addr[base+1]), 32'h01);
        check({tag, "_d1"},    32'(wr_data[base+1]), 32'h08000);
        check({tag, "_count"}, 32'(instr_count), 32'd2);
        check({tag, "_done"},  32'(done), 32'd1);
        check({tag, "_err"},   32'(err), 32'd0);
        check({tag, "_hold"},  32'(cpu_hold), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    task automatic check_error(input string tag, input int base, input int nwr);
        check({tag, "_err"},  32'(err), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_nwr"},  32'(wr_n - base), 32'(nwr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"},    32'(imem_we), 32'd0);
        check({tag, "_addr"},  32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_err"},   32'(err), 32'd0);
        check({tag, "_count"}, 32'(instr_count), 32'd0);
        check({tag, "_hold"},  32'(cpu_hold), 32'd1);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        @(negedge clk);

        // Nominal two-word load
        nominal_stream();
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(8'hA7);
`endif
        base = wr_n;
        pulse_start();
        check("nom_busy_at_start", 32'(busy), 32'd1);
        check("nom_hold_at_start", 32'(cpu_hold), 32'd1);
        foreach (stream[i]) send_byte(stream[i], 0);
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        $display("load nominal: writes=%0d count=%0d done=%0d", wr_n - base, instr_count, done);
        check_nominal("nom", base);

        // Zero length
        stream = '{8'h00, 8'h00};
        base = wr_n;
        run_load("len0", 1'b0);
        check_error("len0", base, 0);

        // Length 257 exceeds depth
        stream = '{8'h01, 8'h01};
        base = wr_n;
        run_load("len257", 1'b0);
        check_error("len257", base, 0);

        // Illegal type 2'b11
        stream = '{8'h01, 8'h00, 8'h00, 8'h80, 8'h01};
        base = wr_n;
        run_load("type11", 1'b0);
        check_error("type11", base, 0);
        check("type11_count", 32'(instr_count), 32'd0);

        // Pad bit set in b2
        stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        base = wr_n;
        run_load("pad", 1'b0);
        check_error("pad", base, 0);

        // Type error on the second word leaves the first written
        stream = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'h00, 8'h80, 8'h01};
        base = wr_n;
        run_load("type11_w1", 1'b0);
        check_error("type11_w1", base, 1);
        check("type11_w1_d0", 32'(wr_data[base]), 32'h11234);

        // Random gaps; valid also stays high through WRITE when gap is zero
        for (int rep = 0; rep < 3; rep++) begin
            nominal_stream();
`ifdef LOADER_CHECKSUM_EN
            stream.push_back(8'hA7);
`endif
            base = wr_n;
            run_load("gaps", 1'b1);
            check_nominal("gaps", base);
        end
        check("ready_in_write", 32'(ready_in_write), 32'd0);

        // Reset after the B1 transfer of word 0
        stream = '{8'h02, 8'h00, 8'h34, 8'h12};
        pulse_start();
        foreach (stream[i]) send_byte(stream[i], 0);
        byte_valid = 1'b0;
        reset = 1'b0;
        #1;
        $display("reset mid-load applied");
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        nominal_stream();
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(8'hA7);
`endif
        base = wr_n;
        run_load("after_rst", 1'b0);
        check_nominal("after_rst", base);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum: words written, core stays held
        nominal_stream();
        stream.push_back(8'h00);
        base = wr_n;
        run_load("csum_bad", 1'b0);
        check_error("csum_bad", base, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
